// File: rtl/neuron_feeder.sv
// neuron_feeder: collects NUM_INPUTS serial (input, weight) pairs into a
// parallel vector for a neuron and presents it with a valid/ready handshake.
// Optional frame-length checking is enabled by defining FEEDER_FRAME_CHECK_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and ready never depends on valid.
module neuron_feeder #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [DATA_W-1:0]            in_weight,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_INPUTS*DATA_W-1:0] out_inputs,
    output logic [NUM_INPUTS*DATA_W-1:0] out_weights,
    output logic                         err_frame,
    output logic                         dbg_state
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int VEC_W = NUM_INPUTS * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   inputs_q, inputs_d;
    logic [VEC_W-1:0]   weights_q, weights_d;
    logic               err_q, err_d;

    logic               accept;
    logic               at_last;
    logic               end_frame;
    logic               frame_err;

    assign at_last = (cnt_q == LAST_IDX);

`ifdef FEEDER_FRAME_CHECK_EN
    // in_last closes a frame early; a missing in_last on the final slot is
    // flagged but the vector still completes on count.
    assign end_frame = at_last | in_last;
    assign frame_err = in_last ^ at_last;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign end_frame   = at_last;
    assign frame_err   = 1'b0;
`endif

    // Ready is held low during reset so nothing is accepted in that cycle.
    assign in_ready    = (state_q == FILL) & ~rst;
    assign out_valid   = (state_q == PRESENT);
    assign accept      = in_valid & in_ready;
    assign out_inputs  = inputs_q;
    assign out_weights = weights_q;
    assign err_frame   = err_q;
    assign dbg_state   = state_q;

    // Next-state logic: slot writes, counter, state transitions, error pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inputs_d  = inputs_q;
        weights_d = weights_q;
        err_d     = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            inputs_d[i*DATA_W +: DATA_W]  = in_data;
                            weights_d[i*DATA_W +: DATA_W] = in_weight;
                        end
                    end
                    err_d = frame_err;
                    if (end_frame) begin
                        state_d = PRESENT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
                // Clearing on the way out gives zero padding for short frames.
                if (out_ready) begin
                    state_d   = FILL;
                    inputs_d  = '0;
                    weights_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            inputs_q  <= '0;
            weights_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inputs_q  <= inputs_d;
            weights_q <= weights_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: directed frames, expected vectors queued by the
// stimulus and consumed by an independent output monitor.
module tb_neuron_feeder;

  localparam int N = 4;
  localparam int W = 8;
  localparam int VW = N * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  in_weight;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_inputs;
  logic [VW-1:0] out_weights;
  logic          err_frame;
  logic          dbg_state;

  logic [2*VW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int err_seen = 0;
  int cyc      = 0;

  neuron_feeder #(.NUM_INPUTS(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_weight   (in_weight),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inputs  (out_inputs),
    .out_weights (out_weights),
    .err_frame   (err_frame),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: offer one pair and wait until it is accepted
  task automatic send_pair(input logic [W-1:0] d, input logic [W-1:0] w, input logic last);
    logic rdy;
    int   budget;
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    budget    = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      budget++;
      if (budget > 50) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor / scoreboard: compares whatever the DUT presents against the queue
  always @(negedge clk) begin
    if (!rst && err_frame) err_seen++;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vector", {out_weights, out_inputs}, 64'd0);
      end else begin
        check("vector", {out_weights, out_inputs}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    int hs_before;
    int cyc_start;
    logic [W-1:0] b2b_d [0:11];
    logic [W-1:0] b2b_w [0:11];

    exp_err   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_err_frame", {63'd0, err_frame}, 64'd0);
    check("rst_vector", {out_weights, out_inputs}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // basic fill
    exp_q.push_back({32'h08060402, 32'h07050301});
    send_pair(8'd1, 8'd2, 1'b0);
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'd5, 8'd6, 1'b0);
    send_pair(8'd7, 8'd8, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("basic_out_valid_latency", {63'd0, out_valid}, 64'd1);
    check("basic_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("basic_in_ready_back", {63'd0, in_ready}, 64'd1);
    check("basic_out_valid_drop", {63'd0, out_valid}, 64'd0);
    check("basic_cleared", {out_weights, out_inputs}, 64'd0);

    // backpressure
    out_ready = 1'b0;
    exp_q.push_back({32'h08060402, 32'h07050301});
    send_pair(8'd1, 8'd2, 1'b0);
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'd5, 8'd6, 1'b0);
    send_pair(8'd7, 8'd8, 1'b1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    hs_before = hs_cnt;
    repeat (5) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_single_handshake", hs_cnt - hs_before, 64'd1);
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);

`ifdef FEEDER_FRAME_CHECK_EN
    // short frame: padded vector plus one-cycle error pulse
    exp_q.push_back({32'h00000101, 32'h00000909});
    send_pair(8'd9, 8'd1, 1'b0);
    send_pair(8'd9, 8'd1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_err++;
    check("short_out_valid", {63'd0, out_valid}, 64'd1);
    check("short_err_pulse", {63'd0, err_frame}, 64'd1);
    @(posedge clk);
    #1;
    check("short_err_end", {63'd0, err_frame}, 64'd0);

    // long frame: completes on count, still flagged
    exp_q.push_back({32'h0D0C0B0A, 32'h04030201});
    send_pair(8'd1, 8'd10, 1'b0);
    send_pair(8'd2, 8'd11, 1'b0);
    send_pair(8'd3, 8'd12, 1'b0);
    send_pair(8'd4, 8'd13, 1'b0);
    in_valid = 1'b0;
    exp_err++;
    check("long_err_pulse", {63'd0, err_frame}, 64'd1);
    check("long_out_valid", {63'd0, out_valid}, 64'd1);
    idle_cycles(2);
`else
    // short frame ignored: vector only after two more pairs
    exp_q.push_back({32'h05030101, 32'h04020909});
    send_pair(8'd9, 8'd1, 1'b0);
    send_pair(8'd9, 8'd1, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) begin
      check("short_no_valid", {63'd0, out_valid}, 64'd0);
      check("short_no_err", {63'd0, err_frame}, 64'd0);
      @(posedge clk);
      #1;
    end
    send_pair(8'd2, 8'd3, 1'b0);
    send_pair(8'd4, 8'd5, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("short_done_valid", {63'd0, out_valid}, 64'd1);
    idle_cycles(2);
`endif

    // reset mid-frame discards the partial vector
    send_pair(8'd55, 8'd66, 1'b0);
    send_pair(8'd77, 8'd88, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFF});
    send_pair(8'hFF, 8'hFF, 1'b0);
    send_pair(8'hFF, 8'hFF, 1'b0);
    send_pair(8'hFF, 8'hFF, 1'b0);
    send_pair(8'hFF, 8'hFF, 1'b1);
    idle_cycles(2);

    // back-to-back frames with in_valid held high
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        b2b_d[k*4+j] = 8'(8'h10 + 8'h20 * k + j);
        b2b_w[k*4+j] = 8'(8'h20 + 8'h20 * k + j);
      end
    end
    exp_q.push_back({32'h23222120, 32'h13121110});
    exp_q.push_back({32'h43424140, 32'h33323130});
    exp_q.push_back({32'h63626160, 32'h53525150});
    hs_before = hs_cnt;
    cyc_start = cyc;
    for (int i = 0; i < 12; i++) begin
      send_pair(b2b_d[i], b2b_w[i], (i % 4) == 3);
    end
    check("b2b_cycles", cyc - cyc_start, 64'd14);
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle_cycles(3);
    check("b2b_handshakes", hs_cnt - hs_before, 64'd3);

    // final accounting
    check("queue_drained", exp_q.size(), 64'd0);
    check("err_pulses", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, operand pairs per vector (legal range 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each input and each weight.
REQ-003 SHALL have port clk  input  1  single clock; every register samples on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers one input/weight pair.
REQ-006 SHALL have port in_ready  output  1  feeder accepts the offered pair.
REQ-007 SHALL have port in_data  input  DATA_W  input sample.
REQ-008 SHALL have port in_weight  input  DATA_W  weight paired with in_data.
REQ-009 SHALL have port in_last  input  1  marks the final pair of a frame.
REQ-010 SHALL have port out_valid  output  1  parallel vector is available to the neuron.
REQ-011 SHALL have port out_ready  input  1  neuron consumes the vector.
REQ-012 SHALL have port out_inputs  output  NUM_INPUTS*DATA_W  inputs; slot i occupies bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port out_weights  output  NUM_INPUTS*DATA_W  weights; same slot packing as out_inputs.
REQ-014 SHALL have port err_frame  output  1  one-cycle pulse on a frame-length error.

Function
REQ-015 SHALL implement two states: FILL and PRESENT.
REQ-016 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; in PRESENT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A pair SHALL be accepted only when in_valid and in_ready are both 1 on a clock edge; the pair is written to slot cnt and cnt increments.
REQ-018 cnt SHALL be a counter of width clog2(NUM_INPUTS+1); it resets to 0 and returns to 0 on each FILL->PRESENT transition.
REQ-019 Accepting the pair at cnt = NUM_INPUTS-1 SHALL move the state to PRESENT on the same edge, so out_valid asserts the cycle after the last accept (1-cycle latency).
REQ-020 In PRESENT, out_inputs and out_weights SHALL hold stable until out_valid and out_ready are both 1; that edge returns the state to FILL.
REQ-021 No bubble SHALL be required: in_ready is 1 in the cycle after the handshake edge.
REQ-022 Slots not written in the current frame SHALL read 0 in PRESENT. The slot array is cleared on each PRESENT->FILL transition.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 Values SHALL pass through unsigned and unmodified; no arithmetic is performed on data.

Reset
REQ-025 While rst = 1, the block SHALL hold: state = FILL, cnt = 0, all slots = 0, out_valid = 0, err_frame = 0, in_ready = 0.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Reset asserted mid-frame or in PRESENT SHALL discard partial or pending vectors with no output handshake.

Configuration
REQ-028 Macro FEEDER_FRAME_CHECK_EN SHALL control frame checking.
REQ-029 With FEEDER_FRAME_CHECK_EN defined, an accepted pair with in_last = 1 and cnt < NUM_INPUTS-1 SHALL:
- move the state to PRESENT on that edge, with the remaining slots zero-padded;
- pulse err_frame for 1 cycle.
REQ-030 With FEEDER_FRAME_CHECK_EN defined, an accepted pair with in_last = 0 at cnt = NUM_INPUTS-1 SHALL complete normally and pulse err_frame for 1 cycle.
REQ-031 Without FEEDER_FRAME_CHECK_EN, in_last SHALL be ignored, err_frame SHALL be tied 0, and vectors complete only on count.

Verification
REQ-032 Scenario, basic fill:
- Stimulus: NUM_INPUTS=4; pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles with in_last on the 4th; out_ready=1.
- Response: out_valid asserts 1 cycle after the 4th accept; out_inputs=0x07050301, out_weights=0x08060402; in_ready returns to 1 the next cycle.
REQ-033 Scenario, backpressure:
- Stimulus: as REQ-032, but out_ready=0 for 5 cycles.
- Response: out_valid stays 1, outputs stay stable, in_ready stays 0 for all 5 cycles; one handshake after out_ready rises.
REQ-034 Scenario, short frame (macro defined):
- Stimulus: pairs (9,1),(9,1), the second with in_last=1.
- Response: err_frame pulses 1 cycle; out_inputs=0x00000909, out_weights=0x00000101.
REQ-035 Scenario, short frame (macro undefined):
- Stimulus: same as REQ-034.
- Response: no out_valid until 2 more pairs are accepted; err_frame stays 0.
REQ-036 Scenario, reset mid-frame:
- Stimulus: 2 pairs accepted, then rst=1 for 1 cycle, then 4 pairs (0xFF,0xFF).
- Response: one vector, all slots 0xFF; no earlier out_valid.
REQ-037 Scenario, back-to-back frames:
- Stimulus: 3 frames streamed with in_valid held at 1 and out_ready=1.
- Response: 3 vectors in order; throughput is 4 accepts plus 1 present cycle per vector.
